// File: rtl/pixel_write_sink.sv
// pixel_write_sink: clips and queues pixels, then writes them to SRAM as SETUP/STROBE/HOLD cycles while granted
module pixel_write_sink #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [19:0] FB_BASE    = 20'h00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  program_x,
  input  logic [9:0]  program_y,
  input  logic [15:0] program_data,
  input  logic        program_write,
  output logic        program_ready,
  input  logic        write_grant,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_drive,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        idle,
  output logic [15:0] dropped_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;
  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [35:0]   r_mem [FIFO_DEPTH];
  logic [19:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   r_dropped;
  logic          r_ce_n;
  logic          r_we_n;
  logic          r_drive;
  logic          w_full;
  logic          w_empty;
  logic          w_in_range;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [19:0]   w_addr;
  assign w_full     = r_count == (PW+1)'(FIFO_DEPTH);
  assign w_empty    = r_count == '0;
  assign w_in_range = (32'(program_x) < H_RES) && (32'(program_y) < V_RES);
  assign w_push     = program_write && !w_full && w_in_range;
  assign w_drop     = program_write && !w_full && !w_in_range;
  assign w_addr     = FB_BASE + 20'(program_y) * 20'(H_RES) + 20'(program_x);
  // A new write may only start from IDLE or back-to-back out of HOLD
  assign w_pop      = write_grant && !w_empty && (r_state == IDLE || r_state == HOLD);
  always_comb begin
    w_next = (r_state == SETUP)  ? STROBE :
             (r_state == STROBE) ? HOLD   :
             w_pop               ? SETUP  : IDLE;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_addr, program_data};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dropped <= '0;
      r_ce_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_drive   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_pop) {r_addr, r_wdata} <= r_mem[r_rd_ptr];
      if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      // Strobes decode the next state so the pins come straight from flops
      r_ce_n  <= w_next == IDLE;
      r_we_n  <= w_next != STROBE;
      r_drive <= w_next != IDLE;
    end
  end
  assign program_ready = !w_full;
  assign sram_addr     = r_addr;
  assign sram_wdata    = r_wdata;
  assign sram_drive    = r_drive;
  assign sram_ce_n     = r_ce_n;
  assign sram_we_n     = r_we_n;
  assign idle          = (r_state == IDLE) && w_empty;
  assign dropped_count = r_dropped;
endmodule
